// File: rtl/rgmii_tx_speed_adapter_if.sv
// Byte stream from the MAC plus the ODDR rise/fall pairs for TXD, TX_CTL and TXC.
interface rgmii_tx_speed_adapter_if;
    logic [7:0] tx_axis_rgmii_tdata;
    logic       tx_axis_rgmii_tvalid;
    logic       tx_axis_rgmii_tready;
    logic [3:0] txd_rise;
    logic [3:0] txd_fall;
    logic       txctl_rise;
    logic       txctl_fall;
    logic       txc_rise;
    logic       txc_fall;

    modport master (
        output tx_axis_rgmii_tdata, tx_axis_rgmii_tvalid,
        input  tx_axis_rgmii_tready, txd_rise, txd_fall,
               txctl_rise, txctl_fall, txc_rise, txc_fall
    );

    modport slave (
        input  tx_axis_rgmii_tdata, tx_axis_rgmii_tvalid,
        output tx_axis_rgmii_tready, txd_rise, txd_fall,
               txctl_rise, txctl_fall, txc_rise, txc_fall
    );
endinterface

// File: rtl/rgmii_tx_speed_adapter.sv
// Paces MAC bytes into 1/10/100-cycle slots at 125 MHz and maps them to RGMII ODDR
// rise/fall pairs; every output is a decode of registers only.
module rgmii_tx_speed_adapter (
    input  logic       tx_mac_aclk,
    input  logic       tx_mac_reset,
    input  logic [1:0] speed,
    output logic [1:0] speed_active,
    rgmii_tx_speed_adapter_if.slave bus
);
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_10   = 2'b00;

    logic       run_q, run_d;
    logic [1:0] spd_q, spd_d;
    logic [6:0] cnt_q, cnt_d;
    logic       txen_q, txen_d;
    logic [7:0] dat_q, dat_d;
    logic [6:0] last_cnt;
    logic [6:0] q_100;
    logic [6:0] q_10;

    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            run_q  <= 1'b0;
            spd_q  <= SPD_1000;
            cnt_q  <= 7'd0;
            txen_q <= 1'b0;
            dat_q  <= 8'd0;
        end else begin
            run_q  <= run_d;
            spd_q  <= spd_d;
            cnt_q  <= cnt_d;
            txen_q <= txen_d;
            dat_q  <= dat_d;
        end
    end

    always_comb begin
        case (spd_q)
            SPD_10:  last_cnt = 7'd99;
            SPD_100: last_cnt = 7'd9;
            default: last_cnt = 7'd0;
        endcase
    end

    // Speed is only re-applied on an idle boundary so a byte is never re-timed.
    always_comb begin
        run_d  = 1'b1;
        spd_d  = spd_q;
        cnt_d  = cnt_q;
        txen_d = txen_q;
        dat_d  = dat_q;
        if (!run_q) begin
            spd_d  = speed;
            cnt_d  = 7'd0;
            txen_d = 1'b0;
            dat_d  = 8'd0;
        end else if (cnt_q == last_cnt) begin
            cnt_d = 7'd0;
            if (bus.tx_axis_rgmii_tvalid) begin
                txen_d = 1'b1;
                dat_d  = bus.tx_axis_rgmii_tdata;
            end else begin
                txen_d = 1'b0;
                dat_d  = 8'd0;
                spd_d  = speed;
            end
        end else begin
            cnt_d = cnt_q + 7'd1;
        end
    end

    assign q_100 = (cnt_q >= 7'd5)  ? cnt_q - 7'd5  : cnt_q;
    assign q_10  = (cnt_q >= 7'd50) ? cnt_q - 7'd50 : cnt_q;

    always_comb begin
        bus.tx_axis_rgmii_tready = 1'b0;
        bus.txd_rise   = 4'd0;
        bus.txd_fall   = 4'd0;
        bus.txctl_rise = 1'b0;
        bus.txctl_fall = 1'b0;
        bus.txc_rise   = 1'b0;
        bus.txc_fall   = 1'b0;
        if (run_q) begin
            bus.tx_axis_rgmii_tready = (cnt_q == last_cnt);
            bus.txctl_rise = txen_q;
            bus.txctl_fall = txen_q;
            case (spd_q)
                SPD_10: begin
                    bus.txd_rise = (cnt_q < 7'd50) ? dat_q[3:0] : dat_q[7:4];
                    bus.txd_fall = (cnt_q < 7'd50) ? dat_q[3:0] : dat_q[7:4];
                    bus.txc_rise = (q_10 < 7'd25);
                    bus.txc_fall = (q_10 < 7'd25);
                end
                SPD_100: begin
                    bus.txd_rise = (cnt_q < 7'd5) ? dat_q[3:0] : dat_q[7:4];
                    bus.txd_fall = (cnt_q < 7'd5) ? dat_q[3:0] : dat_q[7:4];
                    // 2.5 high cycles per 5: the half cycle lives on the rise phase of q = 2
                    bus.txc_rise = (q_100 < 7'd3);
                    bus.txc_fall = (q_100 < 7'd2);
                end
                default: begin
                    bus.txd_rise = dat_q[3:0];
                    bus.txd_fall = dat_q[7:4];
                    bus.txc_rise = 1'b1;
                    bus.txc_fall = 1'b0;
                end
            endcase
        end
    end

    assign speed_active = spd_q;
endmodule

// File: tb/tb_rgmii_tx_speed_adapter.sv
// Directed bench: a slot-queue model predicts every output cycle, plus literal spot checks.
module tb_rgmii_tx_speed_adapter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [1:0] speed_active;

    rgmii_tx_speed_adapter_if bus ();

    rgmii_tx_speed_adapter dut (
        .tx_mac_aclk  (clk),
        .tx_mac_reset (rst),
        .speed        (speed),
        .speed_active (speed_active),
        .bus          (bus)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       tready;
        logic [3:0] dr;
        logic [3:0] df;
        logic       cr;
        logic       cf;
        logic       ctl;
        logic [1:0] spd;
    } rec_t;

    rec_t       mq[$];
    logic       m_started = 1'b0;
    logic [1:0] m_spd = 2'b10;

    // Expands one slot into its per-cycle expected outputs.
    function automatic void build_slot(input logic [1:0] sp, input logic en, input logic [7:0] b);
        int   n;
        int   p;
        rec_t r;
        n = (sp == 2'b00) ? 100 : (sp == 2'b01) ? 10 : 1;
        p = n / 2;
        for (int s = 0; s < n; s++) begin
            r.tready = (s == n - 1);
            r.ctl    = en;
            r.spd    = sp;
            if (n == 1) begin
                r.dr = b[3:0];
                r.df = b[7:4];
                r.cr = 1'b1;
                r.cf = 1'b0;
            end else begin
                r.dr = (s < p) ? b[3:0] : b[7:4];
                r.df = r.dr;
                if (n == 10) begin
                    r.cr = ((s % p) < 3);
                    r.cf = ((s % p) < 2);
                end else begin
                    r.cr = ((s % p) < 25);
                    r.cf = r.cr;
                end
            end
            mq.push_back(r);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_started = 1'b0;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (mq.size() == 0) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_spd = speed;
                    build_slot(m_spd, 1'b0, 8'h00);
                end else if (bus.tx_axis_rgmii_tvalid) begin
                    build_slot(m_spd, 1'b1, bus.tx_axis_rgmii_tdata);
                end else begin
                    m_spd = speed;
                    build_slot(m_spd, 1'b0, 8'h00);
                end
            end
        end
    end

    rec_t exp_r;
    rec_t act_r;
    int   cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (mq.size() > 0) exp_r = mq[0];
        else exp_r = '{tready: 1'b0, dr: 4'h0, df: 4'h0, cr: 1'b0, cf: 1'b0, ctl: 1'b0, spd: 2'b10};
        act_r = {bus.tx_axis_rgmii_tready, bus.txd_rise, bus.txd_fall,
                 bus.txc_rise, bus.txc_fall, bus.txctl_rise, speed_active};
        checks++;
        if (act_r !== exp_r || bus.txctl_fall !== bus.txctl_rise) begin
            errors++;
            $display("FAIL cycle %0d outputs {tready,txd_r,txd_f,txc_r,txc_f,txctl,spd}: got %h (txctl_fall %b) expected %h",
                     cyc, act_r, bus.txctl_fall, exp_r);
        end
    end

    // Run-length monitors for the literal spot checks.
    int ctl_run = 0, last_ctl = 0, low_run = 0, last_low = 0;
    int hi_run = 0, last_hi = 0, last_rise = 0, gap = 0;
    logic prev_tr = 1'b0;

    always @(negedge clk) begin
        if (bus.txctl_rise) begin
            if (low_run > 0) last_low = low_run;
            low_run = 0;
            ctl_run++;
        end else begin
            if (ctl_run > 0) last_ctl = ctl_run;
            ctl_run = 0;
            low_run++;
        end
        if (bus.txc_rise && bus.txc_fall) hi_run++;
        else begin
            if (hi_run > 0) last_hi = hi_run;
            hi_run = 0;
        end
        if (bus.tx_axis_rgmii_tready && !prev_tr) begin
            gap = cyc - last_rise;
            last_rise = cyc;
        end
        prev_tr = bus.tx_axis_rgmii_tready;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns on the negedge after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.tx_axis_rgmii_tvalid = 1'b1;
        bus.tx_axis_rgmii_tdata  = b;
        while (!bus.tx_axis_rgmii_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", (n < 300) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.tx_axis_rgmii_tvalid = 1'b0;
        bus.tx_axis_rgmii_tdata  = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] pre [9];
        pre = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hA3};
        bus.tx_axis_rgmii_tvalid = 1'b0;
        bus.tx_axis_rgmii_tdata  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tready", int'(bus.tx_axis_rgmii_tready), 0);
        chk("reset_speed_active", int'(speed_active), 2);
        rst = 1'b0;
        @(negedge clk);
        chk("gig_tready_after_release", int'(bus.tx_axis_rgmii_tready), 1);

        // 1000M preamble plus 0xA3
        foreach (pre[i]) send(pre[i]);
        chk("gig_a3_rise", int'(bus.txd_rise), 3);
        chk("gig_a3_fall", int'(bus.txd_fall), 10);
        idle(2);
        #1 chk("gig_txctl_run", last_ctl, 9);

        // 100M single byte
        speed = 2'b01;
        idle(3);
        chk("speed_100_applied", int'(speed_active), 1);
        send(8'hA3);
        chk("100_first_nibble", int'(bus.txd_rise), 3);
        idle(5);
        chk("100_second_nibble", int'(bus.txd_fall), 10);
        idle(20);
        #1 chk("100_tready_gap", gap, 10);

        // 100M underrun: one boundary with tvalid low
        send(8'h11);
        send(8'h22);
        idle(10);
        send(8'h33);
        #1 chk("underrun_idle_len", last_low, 10);
        send(8'h44);

        // Speed change requested while tvalid is high
        speed = 2'b10;
        idle(12);
        chk("back_to_gig", int'(speed_active), 2);
        send(8'h01);
        speed = 2'b01;
        send(8'h02);
        chk("change_deferred_a", int'(speed_active), 2);
        send(8'h03);
        chk("change_deferred_b", int'(speed_active), 2);
        idle(1);
        chk("change_applied", int'(speed_active), 1);
        n = 0;
        while (!bus.tx_axis_rgmii_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("change_cnt_restart", n, 9);

        // 10M pacing
        speed = 2'b00;
        idle(12);
        chk("speed_10_applied", int'(speed_active), 0);
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i));
        idle(101);
        #1;
        chk("10_txctl_run", last_ctl, 400);
        chk("10_tready_gap", gap, 100);
        chk("10_txc_high_run", last_hi, 25);

        // Asynchronous reset at slot cycle 37
        send(8'hFF);
        idle(37);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tready", int'(bus.tx_axis_rgmii_tready), 0);
        chk("async_rst_txd", int'({bus.txd_rise, bus.txd_fall}), 0);
        chk("async_rst_txctl", int'({bus.txctl_rise, bus.txctl_fall}), 0);
        chk("async_rst_txc", int'({bus.txc_rise, bus.txc_fall}), 0);
        chk("async_rst_speed", int'(speed_active), 2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reload_speed", int'(speed_active), 0);
        n = 0;
        while (!bus.tx_axis_rgmii_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("first_tready_after_reset", n, 99);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
